// File: rtl/multilane_fifo.sv
// Multi-lane FIFO: pushes and pops up to LANES entries per cycle; a request either completes in full or is rejected in full.
// Latency: a push becomes visible one cycle after its edge; the head lanes are read combinationally.
// Backpressure: a push larger than the free space or a pop larger than the occupancy is dropped, and a one-cycle error pulse follows.
module multilane_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int LANES     = 2,
    parameter int AFULL_LVL = DEPTH - LANES
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic [$clog2(LANES+1)-1:0]   wr_cnt_i,
    input  logic [LANES*WIDTH-1:0]       data_in_i,
    input  logic [$clog2(LANES+1)-1:0]   rd_cnt_i,
    output logic [LANES*WIDTH-1:0]       data_out_o,
    output logic [LANES-1:0]             valid_out_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         afull_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);
    localparam int CW = $clog2(LANES + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [NW-1:0]    count;
    logic             overflow, underflow;

    logic [NW-1:0]    wr_n, rd_n, free;
    logic             wr_fit, rd_fit, wr_acc, rd_acc;

    // Both sides are judged against the pre-edge count, so a same-cycle pop never makes room for a push.
    always_comb begin
        wr_n   = NW'(wr_cnt_i);
        rd_n   = NW'(rd_cnt_i);
        free   = NW'(DEPTH) - count;
        wr_fit = (wr_n <= free);
        rd_fit = (rd_n <= count);
        wr_acc = wr_fit && !flush_i && !reset_i;
        rd_acc = rd_fit && !flush_i && !reset_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(wr_cnt_i);
            if (rd_acc) rd_ptr <= rd_ptr + PW'(rd_cnt_i);
            count     <= count + (wr_acc ? wr_n : '0) - (rd_acc ? rd_n : '0);
            overflow  <= !wr_fit;
            underflow <= !rd_fit;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_acc && (CW'(k) < wr_cnt_i))
                mem[wr_ptr + PW'(k)] <= data_in_i[k*WIDTH +: WIDTH];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign data_out_o[k*WIDTH +: WIDTH] = mem[rd_ptr + PW'(k)];
        assign valid_out_o[k]               = (NW'(k) < count);
    end

    assign count_o     = count;
    assign empty_o     = (count == '0);
    assign full_o      = (count == NW'(DEPTH));
    assign afull_o     = (int'(count) >= AFULL_LVL);
    assign overflow_o  = overflow;
    assign underflow_o = underflow;

endmodule

// File: tb/tb_multilane_fifo.sv
// Directed bench for multilane_fifo at WIDTH=8, DEPTH=8, LANES=2.
module tb_multilane_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  wr_cnt = '0;
    logic [15:0] data_in = '0;
    logic [1:0]  rd_cnt = '0;
    logic [15:0] data_out;
    logic [1:0]  valid_out;
    logic [3:0]  count;
    logic        empty, full, afull, overflow, underflow;

    int checks = 0;
    int errors = 0;

    multilane_fifo #(.WIDTH(8), .DEPTH(8), .LANES(2)) dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .wr_cnt_i(wr_cnt), .data_in_i(data_in), .rd_cnt_i(rd_cnt),
        .data_out_o(data_out), .valid_out_o(valid_out), .count_o(count),
        .empty_o(empty), .full_o(full), .afull_o(afull),
        .overflow_o(overflow), .underflow_o(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int wr, input logic [15:0] din, input int rd, input logic fl);
        wr_cnt  = 2'(wr);
        data_in = din;
        rd_cnt  = 2'(rd);
        flush   = fl;
        @(posedge clk);
        #1;
        wr_cnt = '0;
        rd_cnt = '0;
        flush  = 1'b0;
    endtask

    // Stream table: {wr, rd} per cycle; never overflows or underflows.
    int s_wr [15] = '{2, 2, 1, 2, 2, 2, 1, 2, 2, 2, 2, 0, 0, 0, 0};
    int s_rd [15] = '{0, 1, 2, 2, 1, 2, 0, 2, 1, 2, 0, 2, 2, 2, 1};

    initial begin
        int next_wr, next_rd, mcount;

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(afull), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);

        step(2, 16'h2211, 0, 1'b0);
        chk("push2_count", 32'(count), 2);
        chk("push2_data", 32'(data_out), 32'h2211);
        chk("push2_valid", 32'(valid_out), 2'b11);
        chk("push2_afull", 32'(afull), 0);

        step(2, 16'h4433, 0, 1'b0);
        step(2, 16'h6655, 0, 1'b0);
        chk("cnt6_afull", 32'(afull), 1);
        step(1, 16'h0077, 0, 1'b0);
        chk("cnt7_count", 32'(count), 7);
        chk("cnt7_full", 32'(full), 0);

        step(2, 16'h9988, 0, 1'b0);
        chk("ovf_pulse", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 7);
        step(1, 16'h0088, 0, 1'b0);
        chk("ovf_one_cycle", 32'(overflow), 0);
        chk("fill_count", 32'(count), 8);
        chk("fill_full", 32'(full), 1);
        chk("fill_head", 32'(data_out), 32'h2211);

        step(2, 16'hBBAA, 2, 1'b0);
        chk("pp_ovf", 32'(overflow), 1);
        chk("pp_unf", 32'(underflow), 0);
        chk("pp_count", 32'(count), 6);
        chk("pp_head", 32'(data_out), 32'h4433);
        chk("pp_full", 32'(full), 0);

        step(0, 16'h0000, 2, 1'b0);
        chk("drain_head4", 32'(data_out), 32'h6655);
        step(0, 16'h0000, 2, 1'b0);
        chk("drain_head2", 32'(data_out), 32'h8877);
        step(0, 16'h0000, 1, 1'b0);
        chk("cnt1_valid", 32'(valid_out), 2'b01);
        chk("cnt1_lane0", 32'(data_out[7:0]), 32'h88);

        step(0, 16'h0000, 2, 1'b0);
        chk("unf_pulse", 32'(underflow), 1);
        chk("unf_count", 32'(count), 1);
        step(0, 16'h0000, 1, 1'b0);
        chk("unf_one_cycle", 32'(underflow), 0);
        chk("drain_empty", 32'(empty), 1);
        chk("drain_valid", 32'(valid_out), 0);

        next_wr = 0;
        next_rd = 0;
        mcount  = 0;
        for (int i = 0; i < 15; i++) begin
            for (int k = 0; k < s_rd[i]; k++)
                chk($sformatf("stream_out%0d", next_rd + k),
                    32'(data_out[k*8 +: 8]), 32'(next_rd + k));
            step(s_wr[i], {8'(next_wr + 1), 8'(next_wr)}, s_rd[i], 1'b0);
            next_wr += s_wr[i];
            next_rd += s_rd[i];
            mcount  += s_wr[i] - s_rd[i];
            chk($sformatf("stream_count%0d", i), 32'(count), 32'(mcount));
            chk($sformatf("stream_err%0d", i), 32'({overflow, underflow}), 0);
        end
        chk("stream_total", 32'(next_rd), 20);
        chk("stream_empty", 32'(empty), 1);

        step(2, 16'hA2A1, 0, 1'b0);
        step(2, 16'hA4A3, 0, 1'b0);
        step(1, 16'h00A5, 0, 1'b0);
        chk("preflush_count", 32'(count), 5);
        step(2, 16'hA7A6, 0, 1'b1);
        chk("flush_count", 32'(count), 0);
        chk("flush_empty", 32'(empty), 1);
        chk("flush_err", 32'({overflow, underflow}), 0);
        step(0, 16'h0000, 2, 1'b1);
        chk("flush_unf_masked", 32'(underflow), 0);

        step(2, 16'hC2C1, 0, 1'b0);
        chk("postflush_data", 32'(data_out), 32'hC2C1);
        step(2, 16'hC4C3, 0, 1'b0);
        step(2, 16'hC6C5, 0, 1'b0);
        step(2, 16'hC8C7, 0, 1'b0);
        step(2, 16'hCAC9, 0, 1'b0);
        chk("prereset_ovf", 32'(overflow), 1);
        reset = 1'b1;
        step(2, 16'hD2D1, 1, 1'b0);
        reset = 1'b0;
        chk("midrst_count", 32'(count), 0);
        chk("midrst_valid", 32'(valid_out), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_empty", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
